// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light monitor: lamp phase enum,
// active-high 7-segment digit codes ({g,f,e,d,c,b,a}) and default phase durations.
package tl_pkg;

    typedef enum logic [1:0] {INIT, GREEN, YELLOW, RED} phase_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam int unsigned GREEN_S  = 25;
    localparam int unsigned YELLOW_S = 5;
    localparam int unsigned RED_S    = 30;

endpackage

// File: rtl/seg7_decode.sv
// One 7-segment code back to a BCD digit; valid drops for anything that is not 0..9.
module seg7_decode import tl_pkg::*; #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [6:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    logic [6:0] seg;

    always_comb begin
        seg   = ACTIVE_LOW ? ~code : code;
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light lamps and 4-digit countdown display.
// Registers every input once, then checks lamp encoding, sequence, phase timing and countdown steps.
module traffic_light_monitor import tl_pkg::*; #(
    parameter int unsigned CLK_DIV        = 50_000_000,
    parameter int unsigned GREEN_S        = tl_pkg::GREEN_S,
    parameter int unsigned YELLOW_S       = tl_pkg::YELLOW_S,
    parameter int unsigned RED_S          = tl_pkg::RED_S,
    parameter int unsigned TOL_CYC        = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk50M,
    input  logic       Reset,
    input  logic       clr_err,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic       LR1,
    input  logic       LY1,
    input  logic       LG1,
    input  logic       LR2,
    input  logic       LY2,
    input  logic       LG2,
    output logic [6:0] cnt1,
    output logic [6:0] cnt2,
    output logic       cnt_valid,
    output logic       err_lamp,
    output logic       err_seq,
    output logic       err_seg,
    output logic       err_count,
    output logic       err_time,
    output logic       err_any
);

    localparam int unsigned CW = $clog2(RED_S*CLK_DIV + TOL_CYC + 1);
    localparam logic [CW-1:0] G_LO = CW'(GREEN_S*CLK_DIV - TOL_CYC);
    localparam logic [CW-1:0] G_HI = CW'(GREEN_S*CLK_DIV + TOL_CYC);
    localparam logic [CW-1:0] Y_LO = CW'(YELLOW_S*CLK_DIV - TOL_CYC);
    localparam logic [CW-1:0] Y_HI = CW'(YELLOW_S*CLK_DIV + TOL_CYC);
    localparam logic [CW-1:0] R_LO = CW'(RED_S*CLK_DIV - TOL_CYC);
    localparam logic [CW-1:0] R_HI = CW'(RED_S*CLK_DIV + TOL_CYC);

    // Input stage needs no reset: it only mirrors the pins, and the checks it feeds are reset.
    logic [3:0][6:0] hex_q;
    logic [1:0][2:0] lamp_q, lamp_prev;   // per direction {r,y,g}
    logic            clr_q;

    always_ff @(posedge clk50M) begin
        hex_q     <= {hex3, hex2, hex1, hex0};
        lamp_q    <= {{LR2, LY2, LG2}, {LR1, LY1, LG1}};
        lamp_prev <= lamp_q;
        clr_q     <= clr_err;
    end

    logic [3:0][3:0] dig;
    logic [3:0]      dvld;
    logic            all_vld;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .code  (hex_q[i]),
            .digit (dig[i]),
            .valid (dvld[i])
        );
    end

    assign all_vld = &dvld;

    logic [1:0][6:0] val_new, cnt_r;
    logic [1:0]      set_lamp, set_seq, set_count, set_time;

    for (genvar d = 0; d < 2; d++) begin : g_dir
        phase_t        state, state_nxt, ph_new;
        logic          onehot, chg, chg_d, armed, armed_nxt, legal, in_tol;
        logic          seq_bad, time_bad, step_ok;
        logic [CW-1:0] pcnt, pcnt_nxt, lo, hi;

        assign val_new[d] = 7'(dig[2*d+1]) * 7'd10 + 7'(dig[2*d]);
        assign chg        = lamp_q[d] != lamp_prev[d];

        always_comb begin
            case (lamp_q[d])
                3'b001:  ph_new = GREEN;
                3'b010:  ph_new = YELLOW;
                3'b100:  ph_new = RED;
                default: ph_new = INIT;
            endcase
        end

        assign onehot = ph_new != INIT;
        assign legal  = (state == GREEN  && ph_new == YELLOW) ||
                        (state == YELLOW && ph_new == RED)    ||
                        (state == RED    && ph_new == GREEN);

        always_comb begin
            case (state)
                GREEN:   begin lo = G_LO; hi = G_HI; end
                YELLOW:  begin lo = Y_LO; hi = Y_HI; end
                default: begin lo = R_LO; hi = R_HI; end
            endcase
        end

        assign in_tol = (pcnt >= lo) && (pcnt <= hi);

        always_ff @(posedge clk50M) begin
            if (Reset) begin
                state <= INIT;
                armed <= 1'b0;
                chg_d <= 1'b0;
                pcnt  <= '0;
            end else begin
                state <= state_nxt;
                armed <= armed_nxt;
                chg_d <= chg;
                pcnt  <= pcnt_nxt;
            end
        end

        // armed goes high once a full phase has been entered from a known phase,
        // so the phase that follows INIT is never timed.
        always_comb begin
            state_nxt = state;
            armed_nxt = armed;
            if (onehot && ph_new != state) begin
                state_nxt = ph_new;
                if (state != INIT) armed_nxt = 1'b1;
            end
            if (chg)             pcnt_nxt = CW'(1);
            else if (pcnt != '1) pcnt_nxt = pcnt + CW'(1);
            else                 pcnt_nxt = pcnt;
        end

        always_comb begin
            seq_bad  = 1'b0;
            time_bad = 1'b0;
            if (onehot && state != INIT && ph_new != state) begin
                if (!legal)                seq_bad  = 1'b1;
                else if (armed && !in_tol) time_bad = 1'b1;
            end
        end

        // A step is fine when it counts down by one or the lamps just changed (reload).
        assign step_ok      = (cnt_r[d] != 7'd0 && val_new[d] == cnt_r[d] - 7'd1) || chg || chg_d;
        assign set_lamp[d]  = !onehot;
        assign set_seq[d]   = seq_bad;
        assign set_time[d]  = time_bad;
        assign set_count[d] = all_vld && cnt_valid && (val_new[d] != cnt_r[d]) && !step_ok;
    end

    always_ff @(posedge clk50M) begin
        if (Reset) begin
            cnt_r     <= '0;
            cnt_valid <= 1'b0;
            err_lamp  <= 1'b0;
            err_seq   <= 1'b0;
            err_seg   <= 1'b0;
            err_count <= 1'b0;
            err_time  <= 1'b0;
        end else begin
            cnt_valid <= all_vld;
            if (all_vld) cnt_r <= val_new;
            err_lamp  <= (err_lamp  & ~clr_q) | (|set_lamp) | (lamp_q[0][0] & lamp_q[1][0]);
            err_seq   <= (err_seq   & ~clr_q) | (|set_seq);
            err_seg   <= (err_seg   & ~clr_q) | ~all_vld;
            err_count <= (err_count & ~clr_q) | (|set_count);
            err_time  <= (err_time  & ~clr_q) | (|set_time);
        end
    end

    assign cnt1    = cnt_r[0];
    assign cnt2    = cnt_r[1];
    assign err_any = err_lamp | err_seq | err_seg | err_count | err_time;

endmodule
